// File: rtl/mode_switcher_if.sv
// rtl/mode_switcher_if.sv - source/sink signal bundle for the video mode switcher
interface mode_switcher_if #(
    parameter int NUM_MODES = 4,
    parameter int CH_BITS   = 2,
    parameter int ADDR_W    = 15
);
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int RGB_W  = 3 * CH_BITS;

    // Control from the clock generator, host and timing generator
    logic                          locked;
    logic [MODE_W-1:0]             mode_req;
    logic                          frame_start;
    logic                          can_color;

    // Per-slot source buses; slot k sits at [k*W +: W], slot 0 is unused
    logic [NUM_MODES*RGB_W-1:0]    src_rgb;
    logic [NUM_MODES*ADDR_W-1:0]   src_addr;
    logic [NUM_MODES*8-1:0]        src_side;

    // Selected outputs
    logic [RGB_W-1:0]              rgb;
    logic [ADDR_W-1:0]             vram_addr;
    logic [NUM_MODES-1:0]          mode_en;
    logic                          timing_en;
    logic [7:0]                    side_pixels_remove;
    logic [MODE_W-1:0]             cur_mode;
    logic                          switching;

    modport master (
        output locked,
        output mode_req,
        output frame_start,
        output can_color,
        output src_rgb,
        output src_addr,
        output src_side,
        input  rgb,
        input  vram_addr,
        input  mode_en,
        input  timing_en,
        input  side_pixels_remove,
        input  cur_mode,
        input  switching
    );

    modport slave (
        input  locked,
        input  mode_req,
        input  frame_start,
        input  can_color,
        input  src_rgb,
        input  src_addr,
        input  src_side,
        output rgb,
        output vram_addr,
        output mode_en,
        output timing_en,
        output side_pixels_remove,
        output cur_mode,
        output switching
    );
endinterface

// File: rtl/mode_switcher.sv
// rtl/mode_switcher.sv - video mode switcher with frame-aligned drain/settle; optional border colour via MODE_SWITCH_BORDER_EN
module mode_switcher #(
    parameter int                    NUM_MODES     = 4,
    parameter int                    CH_BITS       = 2,
    parameter int                    ADDR_W        = 15,
    parameter int                    SETTLE_FRAMES = 2,
    parameter logic [3*CH_BITS-1:0]  BLANK_COLOR   = '0
) (
    input  logic          clk,
    input  logic          rst,
    mode_switcher_if.slave bus
);
    localparam int         MODE_W      = $clog2(NUM_MODES);
    localparam int         RGB_W       = 3 * CH_BITS;
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_FRAMES);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [MODE_W-1:0]  cur_mode_q, cur_mode_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;

    logic               req_valid;
    logic               req_other;
    logic [NUM_MODES-1:0] mode_en;
    logic [ADDR_W-1:0]  vram_addr;
    logic [7:0]         side_remove;
    logic               timing_en;

    // Slot 0 is the "disabled" slot; anything at or above NUM_MODES has no source
    always_comb begin
        req_valid = (bus.mode_req != '0) && (int'(bus.mode_req) < NUM_MODES);
        req_other = req_valid && (bus.mode_req != cur_mode_q);
    end

    // Next-state logic; loss of lock overrides everything else
    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        cnt_d      = cnt_q;
        if (!bus.locked) begin
            state_d    = ST_OFF;
            cur_mode_d = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (req_valid) begin
                        state_d    = ST_SETTLE;
                        cur_mode_d = bus.mode_req;
                        cnt_d      = SETTLE_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (!req_valid) begin
                        state_d    = ST_OFF;
                        cur_mode_d = '0;
                        cnt_d      = '0;
                    end else if (req_other) begin
                        state_d = ST_DRAIN;
                    end else if (cnt_q == 4'd0) begin
                        state_d = ST_ACTIVE;
                    end else if (bus.frame_start) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // A frame_start coinciding with the change request is ignored:
                    // DRAIN always waits for a full frame boundary after entry.
                    if (!req_valid) begin
                        state_d    = ST_OFF;
                        cur_mode_d = '0;
                        cnt_d      = '0;
                    end else if (req_other) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The old mode keeps running until the frame boundary
                    if (bus.frame_start) begin
                        if (bus.mode_req == cur_mode_q) begin
                            state_d = ST_ACTIVE;
                        end else if (req_valid) begin
                            state_d    = ST_SETTLE;
                            cur_mode_d = bus.mode_req;
                            cnt_d      = SETTLE_INIT;
                        end else begin
                            state_d    = ST_OFF;
                            cur_mode_d = '0;
                            cnt_d      = '0;
                        end
                    end
                end
                default: begin
                    state_d    = ST_OFF;
                    cur_mode_d = '0;
                    cnt_d      = '0;
                end
            endcase
        end
    end

    // Pixel selection for the next cycle: live source only while ACTIVE
    always_comb begin
        rgb_d = '0;
        if (state_q == ST_ACTIVE && bus.can_color) begin
            rgb_d = bus.src_rgb[int'(cur_mode_q) * RGB_W +: RGB_W];
        end
`ifdef MODE_SWITCH_BORDER_EN
        else if ((state_q == ST_SETTLE || state_q == ST_DRAIN) && bus.can_color) begin
            rgb_d = BLANK_COLOR;
        end
`endif
    end

`ifndef MODE_SWITCH_BORDER_EN
    logic unused_blank;
    assign unused_blank = ^BLANK_COLOR;
`endif

    // State, loaded mode, settle counter and output pixel registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            cur_mode_q <= '0;
            cnt_q      <= '0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            cnt_q      <= cnt_d;
            rgb_q      <= rgb_d;
        end
    end

    // Slot steering follows the loaded mode whenever the pipeline is powered
    always_comb begin
        mode_en     = '0;
        vram_addr   = '0;
        side_remove = '0;
        timing_en   = (state_q != ST_OFF);
        if (state_q != ST_OFF) begin
            mode_en[cur_mode_q] = 1'b1;
            vram_addr           = bus.src_addr[int'(cur_mode_q) * ADDR_W +: ADDR_W];
            side_remove         = bus.src_side[int'(cur_mode_q) * 8 +: 8];
        end
        mode_en[0] = 1'b0;
    end

    assign bus.rgb                = rgb_q;
    assign bus.cur_mode           = cur_mode_q;
    assign bus.mode_en            = mode_en;
    assign bus.timing_en          = timing_en;
    assign bus.vram_addr          = vram_addr;
    assign bus.side_pixels_remove = side_remove;
    assign bus.switching          = (state_q == ST_SETTLE) || (state_q == ST_DRAIN);
endmodule

// File: tb/tb_mode_switcher.sv
// tb/tb_mode_switcher.sv - scoreboard bench for mode_switcher
module tb_mode_switcher;
    localparam int         NM    = 4;
    localparam int         CB    = 2;
    localparam int         AW    = 15;
    localparam int         SF    = 2;
    localparam logic [5:0] BLANK = 6'h15;

    localparam int M_OFF = 0;
    localparam int M_SET = 1;
    localparam int M_ACT = 2;
    localparam int M_DRN = 3;

    logic clk = 1'b0;
    logic rst;

    mode_switcher_if #(.NUM_MODES(NM), .CH_BITS(CB), .ADDR_W(AW)) bus ();

    mode_switcher #(
        .NUM_MODES    (NM),
        .CH_BITS      (CB),
        .ADDR_W       (AW),
        .SETTLE_FRAMES(SF),
        .BLANK_COLOR  (BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  rgb;
        logic [1:0]  cur_mode;
        logic [3:0]  mode_en;
        logic        timing_en;
        logic        switching;
        logic [14:0] vram_addr;
        logic [7:0]  side;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_state  = M_OFF;
    logic [1:0] m_mode = 2'd0;
    int   m_cnt    = 0;
    bit   rand_src = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic go_off();
        m_state = M_OFF;
        m_mode  = 2'd0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        exp_t       e;
        logic [5:0] nrgb;
        logic       valid;
        nrgb = 6'd0;
        if (m_state == M_ACT && bus.can_color)
            nrgb = bus.src_rgb[int'(m_mode) * 6 +: 6];
`ifdef MODE_SWITCH_BORDER_EN
        else if ((m_state == M_SET || m_state == M_DRN) && bus.can_color)
            nrgb = BLANK;
`endif
        valid = (bus.mode_req != 2'd0);
        if (rst) begin
            go_off();
            nrgb = 6'd0;
        end else if (!bus.locked) begin
            go_off();
        end else begin
            case (m_state)
                M_OFF: if (valid) begin
                    m_state = M_SET; m_mode = bus.mode_req; m_cnt = SF;
                end
                M_SET: begin
                    if (!valid) go_off();
                    else if (bus.mode_req != m_mode) m_state = M_DRN;
                    else if (m_cnt == 0) m_state = M_ACT;
                    else if (bus.frame_start) begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) m_state = M_ACT;
                    end
                end
                M_ACT: begin
                    if (!valid) go_off();
                    else if (bus.mode_req != m_mode) m_state = M_DRN;
                end
                default: begin
                    if (bus.frame_start) begin
                        if (bus.mode_req == m_mode) m_state = M_ACT;
                        else if (valid) begin
                            m_state = M_SET; m_mode = bus.mode_req; m_cnt = SF;
                        end else go_off();
                    end
                end
            endcase
        end
        e.rgb       = nrgb;
        e.cur_mode  = m_mode;
        e.timing_en = (m_state != M_OFF);
        e.switching = (m_state == M_SET) || (m_state == M_DRN);
        e.mode_en   = (m_state != M_OFF) ? (4'b0001 << m_mode) : 4'b0000;
        e.vram_addr = (m_state != M_OFF) ? bus.src_addr[int'(m_mode) * 15 +: 15] : 15'd0;
        e.side      = (m_state != M_OFF) ? bus.src_side[int'(m_mode) * 8 +: 8] : 8'd0;
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        if (rand_src) begin
            bus.src_rgb  = 24'($urandom);
            bus.src_addr = 60'({$urandom, $urandom});
            bus.src_side = $urandom;
        end
        model_step();
        @(posedge clk);
        #1;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("rgb", bus.rgb, e.rgb);
            check_eq("cur_mode", bus.cur_mode, e.cur_mode);
            check_eq("mode_en", bus.mode_en, e.mode_en);
            check_eq("timing_en", bus.timing_en, e.timing_en);
            check_eq("switching", bus.switching, e.switching);
            check_eq("vram_addr", bus.vram_addr, e.vram_addr);
            check_eq("side", bus.side_pixels_remove, e.side);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.locked      = 1'b0;
        bus.mode_req    = 2'd0;
        bus.frame_start = 1'b0;
        bus.can_color   = 1'b0;
        bus.src_rgb     = '0;
        bus.src_addr    = '0;
        bus.src_side    = '0;
        idle(2);
        check_eq("rst_timing_en", bus.timing_en, 0);
        check_eq("rst_mode_en", bus.mode_en, 0);

        // Power up into mode 2
        rst = 1'b0; bus.locked = 1'b1; bus.mode_req = 2'd2; bus.can_color = 1'b1;
        step();
        check_eq("up_mode_en", bus.mode_en, 4'b0100);
        check_eq("up_switching", bus.switching, 1);
        idle(3);
        check_eq("up_rgb_blank", bus.rgb, 0);
        pulse();
        idle(2);
        check_eq("up_still_settle", bus.switching, 1);
        pulse();
        check_eq("up_active", bus.switching, 0);
        rand_src = 1'b0;
        bus.src_rgb = {6'h3F, 6'h2A, 6'h15, 6'h00};
        step();
        check_eq("up_rgb_slot2", bus.rgb, 6'h2A);
        rand_src = 1'b1;

        // Switch to mode 1; coincident frame_start must not be consumed
        bus.mode_req = 2'd1; bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check_eq("drn_mode_en", bus.mode_en, 4'b0100);
        check_eq("drn_switching", bus.switching, 1);
        idle(2);
        check_eq("drn_rgb", bus.rgb, 0);
        pulse();
        check_eq("sw_cur_mode", bus.cur_mode, 1);
        check_eq("sw_mode_en", bus.mode_en, 4'b0010);
        pulse();
        pulse();
        check_eq("sw_active", bus.switching, 0);

        // Back to mode 2, then a cancelled drain
        bus.mode_req = 2'd2;
        step(); pulse(); pulse(); pulse();
        bus.mode_req = 2'd1;
        step(); idle(2);
        bus.mode_req = 2'd2;
        idle(1);
        pulse();
        check_eq("cancel_cur_mode", bus.cur_mode, 2);
        check_eq("cancel_mode_en", bus.mode_en, 4'b0100);
        check_eq("cancel_active", bus.switching, 0);

        // Loss of lock during SETTLE
        bus.mode_req = 2'd3;
        step(); pulse(); step();
        bus.locked = 1'b0;
        step();
        check_eq("unlock_timing_en", bus.timing_en, 0);
        check_eq("unlock_mode_en", bus.mode_en, 0);
        check_eq("unlock_vram", bus.vram_addr, 0);
        check_eq("unlock_side", bus.side_pixels_remove, 0);
        bus.locked = 1'b1;
        step();
        check_eq("relock_cur_mode", bus.cur_mode, 3);
        check_eq("relock_switching", bus.switching, 1);

        // mode_req=0 in ACTIVE, settle colour, reset mid-drain
        pulse(); pulse();
        bus.mode_req = 2'd0;
        step();
        check_eq("off_timing_en", bus.timing_en, 0);
        bus.mode_req = 2'd2;
        step();
        bus.can_color = 1'b1;
        step();
`ifdef MODE_SWITCH_BORDER_EN
        check_eq("settle_border", bus.rgb, 6'h15);
`else
        check_eq("settle_border", bus.rgb, 0);
`endif
        bus.can_color = 1'b0;
        step();
        check_eq("settle_nocolor", bus.rgb, 0);
        bus.can_color = 1'b1;
        pulse(); pulse();
        bus.mode_req = 2'd1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_rgb", bus.rgb, 0);
        check_eq("midrst_timing_en", bus.timing_en, 0);
        check_eq("midrst_switching", bus.switching, 0);
        check_eq("midrst_cur_mode", bus.cur_mode, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.locked      = ($urandom_range(0, 49) != 0);
            bus.frame_start = ($urandom_range(0, 7) == 0);
            bus.can_color   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bus.mode_req = 2'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
